lif_n_core: RTL and testbench

- Single leaky integrate-and-fire (LIF) neuron core for the lif_acc accelerator.
- Presynaptic spike indices arrive through an L1 input queue. For each spike, the core adds the spiking neuron's weight column into every postsynaptic membrane potential.
- At the end of the timestep it applies leak and threshold to each neuron and pushes fired neuron indices into an L2 output queue.

---
 rtl/lif_n_core_pkg.sv | 23 ++
 rtl/lif_n_core_spike_fifo.sv | 57 +++++
 rtl/lif_n_core.sv | 150 +++++++++++++++
 tb/tb_lif_n_core.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lif_n_core_pkg.sv
// Shared constants, FSM state codes and datapath typedefs for the LIF neuron core.
package n_core_pkg;

  localparam int DEF_PRESYN     = 32;
  localparam int DEF_POSTSYN    = 32;
  localparam int DEF_SPIKE_W    = 8;
  localparam int DEF_Q_AW       = 5;
  localparam int DEF_WEIGHT_W   = 4;
  localparam int DEF_VMEM_W     = 16;
  localparam int DEF_THRESHOLD  = 48;
  localparam int DEF_LEAK_SHIFT = 4;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t FETCH = 2'd1;
  localparam state_t ACCUM = 2'd2;
  localparam state_t LEAK  = 2'd3;

  typedef logic signed [DEF_VMEM_W-1:0] vmem_t;
  typedef logic [DEF_WEIGHT_W-1:0]      weight_t;

endpackage

// File: rtl/lif_n_core_spike_fifo.sv
// First-word-fall-through spike index queue with synchronous clear.
module spike_fifo #(
  parameter int SPIKE_W = 8,
  parameter int Q_AW    = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               wr,
  input  logic [SPIKE_W-1:0] w_data,
  input  logic               rd,
  output logic [SPIKE_W-1:0] r_data,
  output logic               empty,
  output logic               full
);

  localparam int DEPTH = 1 << Q_AW;

  logic [SPIKE_W-1:0] mem [DEPTH];
  logic [Q_AW-1:0]    wr_ptr;
  logic [Q_AW-1:0]    rd_ptr;
  logic [Q_AW:0]      count;
  logic               do_rd;
  logic               do_wr;

  assign empty  = (count == '0);
  assign full   = (count == (Q_AW+1)'(DEPTH));
  assign do_rd  = rd && !empty;
  // A pop in the same cycle frees a slot, so a full queue still accepts rd+wr.
  assign do_wr  = wr && (!full || do_rd);
  assign r_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr && !clr) mem[wr_ptr] <= w_data;
  end

endmodule

// File: rtl/lif_n_core.sv
// Leaky integrate-and-fire neuron core: accumulates weight columns per input spike,
// then leaks and thresholds every membrane potential once per timestep.
module lif_n_core
  import n_core_pkg::*;
#(
  parameter int PRESYN     = DEF_PRESYN,
  parameter int POSTSYN    = DEF_POSTSYN,
  parameter int SPIKE_W    = DEF_SPIKE_W,
  parameter int Q_AW       = DEF_Q_AW,
  parameter int WEIGHT_W   = DEF_WEIGHT_W,
  parameter int VMEM_W     = DEF_VMEM_W,
  parameter int THRESHOLD  = DEF_THRESHOLD,
  parameter int LEAK_SHIFT = DEF_LEAK_SHIFT
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               en_core,
  input  logic               reset_L1_input_queue,
  input  logic               rd_L1_input_queue,
  input  logic               wr_L1_input_queue,
  input  logic [SPIKE_W-1:0] w_data_L1_input_queue,
  output logic [SPIKE_W-1:0] r_data_L1_input_queue,
  output logic               empty_L1_input_queue,
  output logic               full_L1_input_queue,
  input  logic               reset_L2_output_queue,
  input  logic               rd_L2_output_queue,
  output logic [SPIKE_W-1:0] r_data_L2_output_queue,
  output logic               empty_L2_output_queue,
  output logic               full_L2_output_queue,
  output logic               busy_o
);

  localparam int POST_AW = (POSTSYN > 1) ? $clog2(POSTSYN) : 1;
  localparam int PRE_AW  = (PRESYN > 1) ? $clog2(PRESYN) : 1;

  localparam logic signed [VMEM_W-1:0] VMAX = {1'b0, {(VMEM_W-1){1'b1}}};
  localparam logic signed [VMEM_W-1:0] THR  = VMEM_W'(THRESHOLD);
  localparam logic [POST_AW-1:0]       POST_LAST = POST_AW'(POSTSYN - 1);

  // Weights are preloaded from outside through the simulation hierarchy; reset leaves them intact.
  logic [WEIGHT_W-1:0]      l1_weights_mem [POSTSYN][PRESYN];
  logic signed [VMEM_W-1:0] vmem [POSTSYN];

  state_t              state;
  logic [POST_AW-1:0]  post;
  logic [PRE_AW-1:0]   pre_idx;

  logic                l1_rd;
  logic [SPIKE_W-1:0]  l1_data;
  logic                l1_empty;
  logic                l2_wr;
  logic [SPIKE_W-1:0]  l2_data;

  logic                pre_ok;
  logic                post_last;
  logic [WEIGHT_W-1:0] weight;
  logic [VMEM_W:0]     sum_ext;
  logic signed [VMEM_W-1:0] acc_sum;
  logic signed [VMEM_W-1:0] leaked;
  logic                fire;

  spike_fifo #(
    .SPIKE_W (SPIKE_W),
    .Q_AW    (Q_AW)
  ) u_l1 (
    .clk    (clk_i),
    .rst_n  (rst_i),
    .clr    (reset_L1_input_queue),
    .wr     (wr_L1_input_queue),
    .w_data (w_data_L1_input_queue),
    .rd     (l1_rd),
    .r_data (l1_data),
    .empty  (l1_empty),
    .full   (full_L1_input_queue)
  );

  spike_fifo #(
    .SPIKE_W (SPIKE_W),
    .Q_AW    (Q_AW)
  ) u_l2 (
    .clk    (clk_i),
    .rst_n  (rst_i),
    .clr    (reset_L2_output_queue),
    .wr     (l2_wr),
    .w_data (l2_data),
    .rd     (rd_L2_output_queue),
    .r_data (r_data_L2_output_queue),
    .empty  (empty_L2_output_queue),
    .full   (full_L2_output_queue)
  );

  assign r_data_L1_input_queue = l1_data;
  assign empty_L1_input_queue  = l1_empty;
  assign busy_o                = (state != IDLE);

  // Outside IDLE the core owns the L1 read port; the FIFO ignores pops when empty.
  assign l1_rd = (state == IDLE) ? rd_L1_input_queue : (state == FETCH);

  assign pre_ok    = {1'b0, l1_data} < (SPIKE_W+1)'(PRESYN);
  assign post_last = (post == POST_LAST);
  assign weight    = l1_weights_mem[post][pre_idx];

  // Weights are unsigned and potentials never go negative, so only +max saturation applies.
  assign sum_ext = {vmem[post][VMEM_W-1], vmem[post]}
                 + {{(VMEM_W+1-WEIGHT_W){1'b0}}, weight};
  assign acc_sum = (sum_ext[VMEM_W] != sum_ext[VMEM_W-1]) ? VMAX : sum_ext[VMEM_W-1:0];

  assign leaked = vmem[post] - (vmem[post] >>> LEAK_SHIFT);
  assign fire   = (leaked >= THR);

  assign l2_wr   = (state == LEAK) && fire;
  assign l2_data = SPIKE_W'(post);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state   <= IDLE;
      post    <= '0;
      pre_idx <= '0;
      for (int i = 0; i < POSTSYN; i++) vmem[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (en_core && !l1_empty) state <= FETCH;
        end
        FETCH: begin
          if (l1_empty) begin
            state <= LEAK;
            post  <= '0;
          end else if (pre_ok) begin
            pre_idx <= l1_data[PRE_AW-1:0];
            post    <= '0;
            state   <= ACCUM;
          end
        end
        ACCUM: begin
          vmem[post] <= acc_sum;
          if (post_last) state <= FETCH;
          else           post  <= post + 1'b1;
        end
        LEAK: begin
          vmem[post] <= fire ? '0 : leaked;
          if (post_last) state <= IDLE;
          else           post  <= post + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lif_n_core.sv
// Randomised self-checking bench for lif_n_core against a timestep-level reference model.
module tb_lif_n_core;
  import n_core_pkg::*;

  localparam int PRESYN = 32, POSTSYN = 32, SPIKE_W = 8, Q_AW = 5;
  localparam int WEIGHT_W = 4, VMEM_W = 16, THRESHOLD = 48, LEAK_SHIFT = 4;
  localparam int VMAX = 32767;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  logic en_core = 1'b0;
  logic reset_L1 = 1'b0, rd_L1 = 1'b0, wr_L1 = 1'b0;
  logic [SPIKE_W-1:0] w_data_L1 = '0;
  logic [SPIKE_W-1:0] r_data_L1, r_data_L2;
  logic empty_L1, full_L1, empty_L2, full_L2, busy_o;
  logic reset_L2 = 1'b0, rd_L2 = 1'b0;

  always #5 clk_i = ~clk_i;

  lif_n_core #(
    .PRESYN(PRESYN), .POSTSYN(POSTSYN), .SPIKE_W(SPIKE_W), .Q_AW(Q_AW),
    .WEIGHT_W(WEIGHT_W), .VMEM_W(VMEM_W), .THRESHOLD(THRESHOLD), .LEAK_SHIFT(LEAK_SHIFT)
  ) dut (
    .clk_i                  (clk_i),
    .rst_i                  (rst_i),
    .en_core                (en_core),
    .reset_L1_input_queue   (reset_L1),
    .rd_L1_input_queue      (rd_L1),
    .wr_L1_input_queue      (wr_L1),
    .w_data_L1_input_queue  (w_data_L1),
    .r_data_L1_input_queue  (r_data_L1),
    .empty_L1_input_queue   (empty_L1),
    .full_L1_input_queue    (full_L1),
    .reset_L2_output_queue  (reset_L2),
    .rd_L2_output_queue     (rd_L2),
    .r_data_L2_output_queue (r_data_L2),
    .empty_L2_output_queue  (empty_L2),
    .full_L2_output_queue   (full_L2),
    .busy_o                 (busy_o)
  );

  int n_checks = 0;
  int n_pass = 0;
  int w_model [POSTSYN][PRESYN];
  int v_model [POSTSYN];

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b0;
    en_core = 1'b0; rd_L1 = 1'b0; wr_L1 = 1'b0; rd_L2 = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
    for (int j = 0; j < POSTSYN; j++) v_model[j] = 0;
  endtask

  task automatic load_weights(input bit random_w);
    for (int j = 0; j < POSTSYN; j++)
      for (int i = 0; i < PRESYN; i++) begin
        w_model[j][i] = random_w ? int'($urandom_range(0, 15)) : ((i == j) ? 1 : 2);
        dut.l1_weights_mem[j][i] = WEIGHT_W'(w_model[j][i]);
      end
  endtask

  task automatic push_l1(input logic [SPIKE_W-1:0] d);
    @(negedge clk_i);
    wr_L1 = 1'b1;
    w_data_L1 = d;
    @(negedge clk_i);
    wr_L1 = 1'b0;
  endtask

  function automatic int vmem_diffs();
    int bad = 0;
    for (int j = 0; j < POSTSYN; j++)
      if (int'($unsigned(dut.vmem[j])) != v_model[j]) bad++;
    return bad;
  endfunction

  // Pushes a spike list, runs one timestep and compares potentials, timing and L2 output.
  task automatic apply_stimulus(input string name, input int spikes[$]);
    int exp_fire[$];
    int valid = 0;
    int busy_cycles = 0;
    bit seen = 0, seen_leak = 0, done = 0;
    foreach (spikes[k]) begin
      push_l1(SPIKE_W'(spikes[k]));
      if (spikes[k] < PRESYN) begin
        valid++;
        for (int j = 0; j < POSTSYN; j++) begin
          v_model[j] += w_model[j][spikes[k]];
          if (v_model[j] > VMAX) v_model[j] = VMAX;
        end
      end
    end
    @(negedge clk_i);
    en_core = 1'b1;
    for (int c = 0; c < 4000 && !done; c++) begin
      @(negedge clk_i);
      if (busy_o) begin
        busy_cycles++;
        seen = 1;
        en_core = 1'b0;
      end else if (seen) done = 1;
      if (dut.state == LEAK && !seen_leak) begin
        seen_leak = 1;
        check_output({name, " pre-leak vmem diffs"}, vmem_diffs(), 0);
      end
    end
    en_core = 1'b0;
    check_output({name, " timestep completed"}, 32'(done), 1);
    check_output({name, " leak phase reached"}, 32'(seen_leak), 1);
    check_output({name, " busy cycles"}, busy_cycles,
                 spikes.size() + valid * POSTSYN + 1 + POSTSYN);
    for (int j = 0; j < POSTSYN; j++) begin
      int vl = v_model[j] - (v_model[j] >>> LEAK_SHIFT);
      if (vl >= THRESHOLD) begin
        if (exp_fire.size() < (1 << Q_AW)) exp_fire.push_back(j);
        v_model[j] = 0;
      end else v_model[j] = vl;
    end
    check_output({name, " post-leak vmem diffs"}, vmem_diffs(), 0);
    check_output({name, " L2 empty"}, 32'(empty_L2), 32'(exp_fire.size() == 0));
    check_output({name, " L2 full"}, 32'(full_L2), 32'(exp_fire.size() == (1 << Q_AW)));
    while (exp_fire.size() > 0) begin
      @(negedge clk_i);
      check_output({name, " L2 index"}, 32'(r_data_L2), exp_fire.pop_front());
      rd_L2 = 1'b1;
    end
    @(negedge clk_i);
    rd_L2 = 1'b0;
    check_output({name, " L2 drained"}, 32'(empty_L2), 1);
  endtask

  initial begin
    int q[$];
    int spikes[$];
    logic [SPIKE_W-1:0] d;
    int bad;
    bit hit;

    $display("[TB] starting lif_n_core bench");
    do_reset();
    check_output("reset L1 empty", 32'(empty_L1), 1);
    check_output("reset L1 full", 32'(full_L1), 0);
    check_output("reset L1 r_data", 32'(r_data_L1), 0);
    check_output("reset L2 empty", 32'(empty_L2), 1);
    check_output("reset L2 full", 32'(full_L2), 0);
    check_output("reset L2 r_data", 32'(r_data_L2), 0);
    check_output("reset busy", 32'(busy_o), 0);
    check_output("reset vmem diffs", vmem_diffs(), 0);

    // L1 fill, overflow, rd+wr at full, ordered drain across the pointer wrap.
    for (int i = 0; i < 32; i++) begin
      d = SPIKE_W'($urandom_range(0, 255));
      push_l1(d);
      q.push_back(int'(d));
    end
    check_output("L1 full after 32", 32'(full_L1), 1);
    check_output("L1 head after fill", 32'(r_data_L1), q[0]);
    push_l1(8'hA5);
    check_output("L1 full after 33rd", 32'(full_L1), 1);
    d = SPIKE_W'($urandom_range(0, 255));
    @(negedge clk_i);
    rd_L1 = 1'b1; wr_L1 = 1'b1; w_data_L1 = d;
    @(negedge clk_i);
    rd_L1 = 1'b0; wr_L1 = 1'b0;
    void'(q.pop_front());
    q.push_back(int'(d));
    check_output("L1 full after rd+wr", 32'(full_L1), 1);
    while (q.size() > 0) begin
      @(negedge clk_i);
      check_output("L1 drain data", 32'(r_data_L1), q.pop_front());
      rd_L1 = 1'b1;
    end
    @(negedge clk_i);
    rd_L1 = 1'b0;
    check_output("L1 empty after drain", 32'(empty_L1), 1);

    push_l1(8'd7);
    @(negedge clk_i);
    reset_L1 = 1'b1; wr_L1 = 1'b1; w_data_L1 = 8'd9;
    @(negedge clk_i);
    reset_L1 = 1'b0; wr_L1 = 1'b0;
    check_output("L1 clear beats write", 32'(empty_L1), 1);

    load_weights(1'b0);
    do_reset();
    spikes = '{3};
    apply_stimulus("single spike", spikes);

    do_reset();
    spikes = {};
    for (int i = 1; i < 32; i++) spikes.push_back(i);
    apply_stimulus("full timestep", spikes);

    load_weights(1'b1);
    do_reset();
    for (int t = 0; t < 6; t++) begin
      spikes = {};
      for (int k = 0; k < int'($urandom_range(1, 10)); k++)
        spikes.push_back(int'($urandom_range(0, 39)));
      apply_stimulus($sformatf("random step %0d", t), spikes);
    end

    // Reset while the core is accumulating must not disturb the weights.
    push_l1(8'd4);
    push_l1(8'd9);
    @(negedge clk_i);
    en_core = 1'b1;
    hit = 0;
    for (int c = 0; c < 200 && !hit; c++) begin
      @(negedge clk_i);
      if (dut.state == ACCUM) hit = 1;
    end
    check_output("reached ACCUM", 32'(hit), 1);
    rst_i = 1'b0;
    en_core = 1'b0;
    @(negedge clk_i);
    for (int j = 0; j < POSTSYN; j++) v_model[j] = 0;
    check_output("mid-accum reset busy", 32'(busy_o), 0);
    check_output("mid-accum reset L1 empty", 32'(empty_L1), 1);
    check_output("mid-accum reset L2 empty", 32'(empty_L2), 1);
    check_output("mid-accum reset vmem diffs", vmem_diffs(), 0);
    rst_i = 1'b1;
    bad = 0;
    for (int j = 0; j < POSTSYN; j++)
      for (int i = 0; i < PRESYN; i++)
        if (int'(dut.l1_weights_mem[j][i]) != w_model[j][i]) bad++;
    check_output("weights kept across reset", bad, 0);

    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
